hucard_bridge: RTL and testbench

HUCARD_BRIDGE -- requirements
Module: hucard_bridge

---
 rtl/hucard_bridge.sv | 233 +++++++++++++++++++++++
 tb/tb_hucard_bridge.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hucard_bridge.sv
// hucard_bridge -- host register interface to a HuCard-style card bus.
//
// The host programs an address through ADL/ADM/ADH and then launches a card
// cycle. A DATA write launches a card write cycle. A CMD write with bit0 set
// launches a card read cycle. Each cycle runs through SETUP, STROBE and HOLD.
// All card-side outputs are registered, so the strobes are glitch-free.
//
// Ports:
//   clock, reset_n              system clock, async active-low reset
//   host_wr, host_rd            one-clock host register write / read requests
//   host_reg, host_wdata        register select and write data
//   host_rdata                  registered read data
//   host_busy                   card cycle in progress
//   irq                         card interrupt, gated by CTRL.irq_en
//   ha, hd_out, hd_oe           card address, write data and its output enable
//   hd_in                       card read data
//   hwr_n, hrd_n                card write / read strobes (active-low)
//   hsm, hreset_n               card mode select and card reset (from CTRL)
//   card_detect_n, hirq2_n      asynchronous card status inputs
module hucard_bridge #(
  parameter int ADDR_WIDTH    = 21,
  parameter int SETUP_CYCLES  = 1,
  parameter int STROBE_CYCLES = 3,
  parameter int HOLD_CYCLES   = 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  host_wr,
  input  logic                  host_rd,
  input  logic [2:0]            host_reg,
  input  logic [7:0]            host_wdata,
  output logic [7:0]            host_rdata,
  output logic                  host_busy,
  output logic                  irq,
  output logic [ADDR_WIDTH-1:0] ha,
  input  logic [7:0]            hd_in,
  output logic [7:0]            hd_out,
  output logic                  hd_oe,
  output logic                  hwr_n,
  output logic                  hrd_n,
  output logic                  hsm,
  output logic                  hreset_n,
  input  logic                  card_detect_n,
  input  logic                  hirq2_n
);

  localparam int AHW = ADDR_WIDTH - 16;

  localparam logic [2:0] REG_ADL    = 3'd0;
  localparam logic [2:0] REG_ADM    = 3'd1;
  localparam logic [2:0] REG_ADH    = 3'd2;
  localparam logic [2:0] REG_DATA   = 3'd3;
  localparam logic [2:0] REG_CTRL   = 3'd4;
  localparam logic [2:0] REG_STATUS = 3'd5;
  localparam logic [2:0] REG_CMD    = 3'd6;

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  state_t                  state_q;
  logic [15:0]             cnt_q;
  logic                    is_write_q;
  logic [7:0]              adl_q, adm_q, adl_d, adm_d;
  logic [AHW-1:0]          adh_q, adh_d;
  logic [3:0]              ctrl_q;
  logic [7:0]              rd_buf_q, hd_out_q, host_rdata_q;
  logic                    rd_valid_q, overrun_q;
  logic [ADDR_WIDTH-1:0]   ha_q;
  logic                    hd_oe_q, hwr_n_q, hrd_n_q;
  logic                    cd_meta_q, cd_sync_q, irq_meta_q, irq_sync_q;

  logic                    busy, rd_en, cycle_req, launch, last, inc_en, capture;
  logic [ADDR_WIDTH-1:0]   addr_cur, addr_inc;
  logic [7:0]              rdata_sel;

  // Two-flop synchronisers. Their reset value of 1 is the inactive level.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cd_meta_q  <= 1'b1;
      cd_sync_q  <= 1'b1;
      irq_meta_q <= 1'b1;
      irq_sync_q <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the pre-edge
      // value of its source, which is what a synchroniser chain requires.
      cd_meta_q  <= card_detect_n;
      cd_sync_q  <= cd_meta_q;
      irq_meta_q <= hirq2_n;
      irq_sync_q <= irq_meta_q;
    end
  end

  assign busy      = (state_q != IDLE);
  // When a write and a read arrive together, the write is performed and the read is dropped.
  assign rd_en     = host_rd && !host_wr;
  assign cycle_req = host_wr && ((host_reg == REG_DATA) ||
                                 ((host_reg == REG_CMD) && host_wdata[0]));
  assign launch    = cycle_req && !busy;
  assign last      = (cnt_q == 16'd0);
  assign inc_en    = (state_q == HOLD) && last && ctrl_q[0];
  assign capture   = (state_q == STROBE) && last && !is_write_q;
  assign addr_cur  = {adh_q, adm_q, adl_q};
  assign addr_inc  = addr_cur + ADDR_WIDTH'(1);

  // Address byte next-state. The increment is applied to every byte first.
  // A host write to a byte then overrides the increment for that byte only.
  always_comb begin
    // NOTE: each output of this block gets a default value first, so no
    // path can leave it unassigned and infer a latch.
    adl_d = adl_q;
    adm_d = adm_q;
    adh_d = adh_q;
    if (inc_en) begin
      adl_d = addr_inc[7:0];
      adm_d = addr_inc[15:8];
      adh_d = addr_inc[ADDR_WIDTH-1:16];
    end
    if (host_wr && (host_reg == REG_ADL)) adl_d = host_wdata;
    if (host_wr && (host_reg == REG_ADM)) adm_d = host_wdata;
    if (host_wr && (host_reg == REG_ADH)) adh_d = host_wdata[AHW-1:0];
  end

  always_comb begin
    rdata_sel = 8'hA6;
    case (host_reg)
      REG_ADL:    rdata_sel = adl_q;
      REG_ADM:    rdata_sel = adm_q;
      REG_ADH:    rdata_sel = 8'(adh_q);
      REG_DATA:   rdata_sel = rd_buf_q;
      REG_CTRL:   rdata_sel = {4'b0000, ctrl_q};
      REG_STATUS: rdata_sel = {3'b000, rd_valid_q, irq_sync_q, cd_sync_q, overrun_q, busy};
      REG_CMD:    rdata_sel = 8'h00;
      default:    rdata_sel = 8'hA6;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cnt_q        <= 16'd0;
      is_write_q   <= 1'b0;
      adl_q        <= 8'h00;
      adm_q        <= 8'h00;
      adh_q        <= '0;
      ctrl_q       <= 4'h0;
      rd_buf_q     <= 8'h00;
      rd_valid_q   <= 1'b0;
      overrun_q    <= 1'b0;
      hd_out_q     <= 8'h00;
      host_rdata_q <= 8'h00;
      ha_q         <= '0;
      hd_oe_q      <= 1'b0;
      hwr_n_q      <= 1'b1;
      hrd_n_q      <= 1'b1;
    end else begin
      adl_q <= adl_d;
      adm_q <= adm_d;
      adh_q <= adh_d;

      if (host_wr && (host_reg == REG_CTRL)) ctrl_q <= host_wdata[3:0];

      if (cycle_req && busy)
        overrun_q <= 1'b1;
      else if (host_wr && (host_reg == REG_STATUS) && host_wdata[1])
        overrun_q <= 1'b0;

      if (rd_en) host_rdata_q <= rdata_sel;

      // Fresh card data outranks a simultaneous DATA read of the old value.
      if (capture) begin
        rd_buf_q   <= hd_in;
        rd_valid_q <= 1'b1;
      end else if (rd_en && (host_reg == REG_DATA)) begin
        rd_valid_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (launch) begin
            is_write_q <= (host_reg == REG_DATA);
            ha_q       <= addr_cur;
            if (host_reg == REG_DATA) begin
              hd_out_q <= host_wdata;
              hd_oe_q  <= 1'b1;
            end
            cnt_q   <= 16'(SETUP_CYCLES - 1);
            state_q <= SETUP;
          end
        end
        SETUP: begin
          if (last) begin
            if (is_write_q) hwr_n_q <= 1'b0;
            else            hrd_n_q <= 1'b0;
            cnt_q   <= 16'(STROBE_CYCLES - 1);
            state_q <= STROBE;
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        STROBE: begin
          if (last) begin
            hwr_n_q <= 1'b1;
            hrd_n_q <= 1'b1;
            cnt_q   <= 16'(HOLD_CYCLES - 1);
            state_q <= HOLD;
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        HOLD: begin
          if (last) begin
            hd_oe_q <= 1'b0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign host_rdata = host_rdata_q;
  assign host_busy  = busy;
  assign irq        = ctrl_q[3] & ~irq_sync_q;
  assign ha         = ha_q;
  assign hd_out     = hd_out_q;
  assign hd_oe      = hd_oe_q;
  assign hwr_n      = hwr_n_q;
  assign hrd_n      = hrd_n_q;
  assign hreset_n   = ctrl_q[1];
  assign hsm        = ctrl_q[2];

endmodule

// File: tb/tb_hucard_bridge.sv
// tb_hucard_bridge -- self-checking bench for hucard_bridge.
// The reference model tracks the programmed address as a plain integer. It
// also tracks the control and status flags. It derives the expected strobe
// timing of a card cycle from the three timing parameters.
module tb_hucard_bridge;

  localparam int AW    = 21;
  localparam int S     = 1;
  localparam int T     = 3;
  localparam int H     = 1;
  localparam int TOTAL = S + T + H;
  localparam int unsigned MASK = (32'd1 << AW) - 1;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          host_wr, host_rd;
  logic [2:0]    host_reg;
  logic [7:0]    host_wdata, host_rdata;
  logic          host_busy, irq;
  logic [AW-1:0] ha;
  logic [7:0]    hd_in, hd_out;
  logic          hd_oe, hwr_n, hrd_n, hsm, hreset_n;
  logic          card_detect_n, hirq2_n;

  int errors = 0;
  int checks = 0;

  // Reference model state.
  int unsigned m_addr;
  logic [3:0]  m_ctrl;
  bit          m_overrun, m_rd_valid;
  logic [7:0]  m_rd_buf, m_hd_out;

  hucard_bridge #(
    .ADDR_WIDTH(AW), .SETUP_CYCLES(S), .STROBE_CYCLES(T), .HOLD_CYCLES(H)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .host_wr(host_wr), .host_rd(host_rd), .host_reg(host_reg),
    .host_wdata(host_wdata), .host_rdata(host_rdata), .host_busy(host_busy),
    .irq(irq), .ha(ha), .hd_in(hd_in), .hd_out(hd_out), .hd_oe(hd_oe),
    .hwr_n(hwr_n), .hrd_n(hrd_n), .hsm(hsm), .hreset_n(hreset_n),
    .card_detect_n(card_detect_n), .hirq2_n(hirq2_n)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Host accesses are asserted on a falling edge and held over one rising edge.
  task automatic host_write(input logic [2:0] r, input logic [7:0] d);
    @(negedge clock);
    // NOTE: the bench drives inputs with blocking assignments away from the
    // rising edge, so the DUT never races the stimulus.
    host_wr = 1'b1; host_reg = r; host_wdata = d;
    @(negedge clock);
    host_wr = 1'b0;
  endtask

  task automatic host_read(input logic [2:0] r, output logic [7:0] d);
    @(negedge clock);
    host_rd = 1'b1; host_reg = r;
    @(negedge clock);
    host_rd = 1'b0;
    d = host_rdata;
  endtask

  task automatic read_check(input logic [2:0] r, input logic [7:0] exp, input string tag);
    logic [7:0] d;
    host_read(r, d);
    check(tag, d, exp);
    if (r == 3'd3) m_rd_valid = 1'b0;
  endtask

  task automatic set_addr(input int unsigned a);
    host_write(3'd0, a[7:0]);
    host_write(3'd1, a[15:8]);
    host_write(3'd2, a[23:16]);
    m_addr = a & MASK;
  endtask

  task automatic set_ctrl(input logic [3:0] c);
    host_write(3'd4, {4'h0, c});
    m_ctrl = c;
  endtask

  function automatic logic [7:0] status_exp();
    return {3'b000, m_rd_valid, hirq2_n, card_detect_n, m_overrun, 1'b0};
  endfunction

  // Launch one card cycle and check every clock of it against the timing profile.
  task automatic run_cycle(input bit is_wr, input logic [7:0] data, input string tag);
    int unsigned exp_ha;
    bit strobe, active;
    exp_ha = m_addr;
    if (is_wr) host_write(3'd3, data);
    else       host_write(3'd6, 8'h01);
    for (int k = 1; k <= TOTAL + 1; k++) begin
      if (k > 1) @(negedge clock);
      strobe = (k > S) && (k <= S + T);
      active = (k <= TOTAL);
      check($sformatf("%s busy k%0d", tag, k), host_busy, active);
      check($sformatf("%s hwr_n k%0d", tag, k), hwr_n, !(is_wr && strobe));
      check($sformatf("%s hrd_n k%0d", tag, k), hrd_n, !(!is_wr && strobe));
      check($sformatf("%s hd_oe k%0d", tag, k), hd_oe, is_wr && active);
    end
    if (is_wr) m_hd_out = data;
    check({tag, " ha"}, ha, exp_ha);
    check({tag, " hd_out"}, hd_out, m_hd_out);
    if (m_ctrl[0]) m_addr = (m_addr + 1) & MASK;
    if (!is_wr) begin
      m_rd_buf   = hd_in;
      m_rd_valid = 1'b1;
    end
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (host_busy && n < 50) begin
      @(negedge clock);
      n++;
    end
    check({tag, " idle timeout"}, host_busy, 1'b0);
  endtask

  initial begin
    int n;
    logic [7:0] d;
    reset_n = 1'b0; host_wr = 1'b0; host_rd = 1'b0; host_reg = 3'd0;
    host_wdata = 8'h00; hd_in = 8'h00; card_detect_n = 1'b0; hirq2_n = 1'b1;
    m_addr = 0; m_ctrl = 4'h0; m_overrun = 1'b0; m_rd_valid = 1'b0;
    m_rd_buf = 8'h00; m_hd_out = 8'h00;

    // Reset state.
    repeat (3) @(negedge clock);
    check("rst hwr_n", hwr_n, 1'b1);
    check("rst hrd_n", hrd_n, 1'b1);
    check("rst hd_oe", hd_oe, 1'b0);
    check("rst hreset_n", hreset_n, 1'b0);
    check("rst hsm", hsm, 1'b0);
    check("rst irq", irq, 1'b0);
    check("rst ha", ha, 0);
    check("rst hd_out", hd_out, 8'h00);
    check("rst host_rdata", host_rdata, 8'h00);
    check("rst busy", host_busy, 1'b0);
    reset_n = 1'b1;
    repeat (3) @(negedge clock);

    read_check(3'd7, 8'hA6, "ID");
    read_check(3'd5, status_exp(), "status after reset");
    read_check(3'd6, 8'h00, "CMD reads 0");

    // Directed write cycle at 0x011234.
    set_addr(32'h011234);
    run_cycle(1'b1, 8'h5A, "wr cycle");
    read_check(3'd0, 8'h34, "ADL readback");
    read_check(3'd2, 8'h01, "ADH readback");

    // CTRL drives hreset_n/hsm and enables auto-increment.
    set_ctrl(4'h7);
    @(negedge clock);
    check("hreset_n", hreset_n, 1'b1);
    check("hsm", hsm, 1'b1);
    read_check(3'd4, 8'h07, "CTRL readback");

    // Auto-increment wrap from all-ones.
    set_addr(32'h1FFFFF);
    run_cycle(1'b1, 8'h11, "wrap c1");
    read_check(3'd0, 8'h00, "wrap ADL");
    read_check(3'd1, 8'h00, "wrap ADM");
    read_check(3'd2, 8'h00, "wrap ADH");
    run_cycle(1'b1, 8'h22, "wrap c2");
    check("wrap c2 model addr", m_addr, 1);

    // Read cycle.
    hd_in = 8'hC3;
    run_cycle(1'b0, 8'h00, "rd cycle");
    read_check(3'd5, status_exp(), "status rd_valid set");
    read_check(3'd3, 8'hC3, "DATA read");
    read_check(3'd3, 8'hC3, "DATA reread");
    read_check(3'd5, status_exp(), "status rd_valid clear");

    // Overrun: an address write and a DATA write both arrive while busy.
    set_addr(32'h000010);
    host_write(3'd3, 8'h11);
    host_write(3'd0, 8'h20);
    host_write(3'd3, 8'h22);
    m_overrun = 1'b1;
    wait_idle("overrun");
    check("overrun ha unchanged", ha, 32'h10);
    check("overrun hd_out", hd_out, 8'h11);
    m_addr = 32'h21;
    read_check(3'd0, 8'h21, "overrun ADL");
    read_check(3'd5, status_exp(), "status overrun set");
    host_write(3'd5, 8'h02);
    m_overrun = 1'b0;
    read_check(3'd5, status_exp(), "status overrun clear");

    // A host write to ADM lands on the increment edge and wins for that byte.
    set_addr(32'h0000FF);
    host_write(3'd3, 8'h44);
    repeat (TOTAL - 2) @(negedge clock);
    host_write(3'd1, 8'h55);
    check("coincide busy", host_busy, 1'b0);
    read_check(3'd0, 8'h00, "coincide ADL");
    read_check(3'd1, 8'h55, "coincide ADM");
    read_check(3'd2, 8'h00, "coincide ADH");
    m_addr = 32'h005500;

    // Simultaneous write and read: the write happens and the read is dropped.
    read_check(3'd7, 8'hA6, "ID before wr+rd");
    @(negedge clock);
    host_wr = 1'b1; host_rd = 1'b1; host_reg = 3'd0; host_wdata = 8'h77;
    @(negedge clock);
    host_wr = 1'b0; host_rd = 1'b0;
    check("wr+rd rdata held", host_rdata, 8'hA6);
    read_check(3'd0, 8'h77, "wr+rd ADL written");
    m_addr = 32'h005577;

    // Randomized cycles against the model.
    for (int i = 0; i < 8; i++) begin
      bit is_wr;
      set_addr($urandom & 32'hFFFFFF);
      is_wr = 1'($urandom_range(0, 1));
      hd_in = 8'($urandom);
      run_cycle(is_wr, 8'($urandom), $sformatf("rand%0d", i));
      read_check(3'd0, m_addr[7:0], $sformatf("rand%0d ADL", i));
      read_check(3'd1, m_addr[15:8], $sformatf("rand%0d ADM", i));
      read_check(3'd2, m_addr[23:16], $sformatf("rand%0d ADH", i));
      if (!is_wr) read_check(3'd3, m_rd_buf, $sformatf("rand%0d DATA", i));
      read_check(3'd5, status_exp(), $sformatf("rand%0d status", i));
    end

    // Interrupt through the synchroniser.
    set_ctrl(4'hF);
    hirq2_n = 1'b0;
    n = 0;
    while (!irq && n < 6) begin
      @(negedge clock);
      n++;
    end
    check("irq rises", irq, 1'b1);
    check("irq latency in 2..3", (n >= 2 && n <= 3), 1'b1);
    set_ctrl(4'h7);
    @(negedge clock);
    check("irq gated by irq_en", irq, 1'b0);
    hirq2_n = 1'b1;
    read_check(3'd7, 8'hA6, "ID again");

    // Reset asserted during STROBE aborts the cycle.
    set_addr(32'h000000);
    host_write(3'd3, 8'h99);
    @(negedge clock);
    check("abort in strobe", hwr_n, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    check("abort hwr_n", hwr_n, 1'b1);
    check("abort hd_oe", hd_oe, 1'b0);
    check("abort busy", host_busy, 1'b0);
    #1 reset_n = 1'b1;
    m_ctrl = 4'h0; m_overrun = 1'b0; m_rd_valid = 1'b0; m_addr = 0;
    repeat (TOTAL + 2) @(negedge clock);
    check("abort idle", host_busy, 1'b0);
    check("abort ha", ha, 0);
    check("abort hreset_n", hreset_n, 1'b0);
    read_check(3'd0, 8'h00, "abort ADL");
    read_check(3'd1, 8'h00, "abort ADM");
    read_check(3'd2, 8'h00, "abort ADH");
    read_check(3'd5, status_exp(), "abort status");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
